// File: rtl/video_bilinear_interp.sv
// Fetches a 2x2 source neighbourhood and bilinearly blends it to one pixel.
// Define VIDEO_BILINEAR_EN for bilinear; default build is nearest-neighbour.
module video_bilinear_interp #(
  parameter int          SRC_W    = 64,
  parameter int          SRC_H    = 64,
  parameter int          ADDR_W   = 12,
  parameter logic [7:0]  BG_PIXEL = 8'h00
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              coord_valid,
  output logic              coord_ready,
  input  logic [31:0]       coord_x,
  input  logic [31:0]       coord_y,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_out,
  output logic              busy
);

`ifdef VIDEO_BILINEAR_EN
  localparam int NFETCH = 4;
`else
  localparam int NFETCH = 1;
`endif

  localparam logic signed [15:0] XMAX = 16'(SRC_W - 1);
  localparam logic signed [15:0] YMAX = 16'(SRC_H - 1);
  localparam logic [ADDR_W-1:0]  W_A  = ADDR_W'(SRC_W);
  localparam logic [1:0]         CLST = 2'(NFETCH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_CALC,
    S_OUT
  } state_e;

  state_e            state_q;
  logic [15:0]       x0_q, y0_q;
  logic [15:0]       x1_q, y1_q;
  logic [7:0]        fx_q, fy_q;
  logic [1:0]        cnt_q;
  logic              cap_q;
  logic [1:0]        cap_idx_q;
  logic [7:0]        p_q [4];
  logic [7:0]        pix_q;
  logic [ADDR_W-1:0] addr_hold_q;

  logic signed [15:0] xi_w, yi_w;
  logic [15:0]        x1_w, y1_w;
  logic               in_rng_w;
  logic [15:0]        xs_w, ys_w;
  logic [ADDR_W-1:0]  addr_w;
  logic [7:0]         calc_w;

  assign xi_w     = coord_x[31:16];
  assign yi_w     = coord_y[31:16];
  assign in_rng_w = (xi_w >= 16'sd0) && (xi_w <= XMAX) &&
                    (yi_w >= 16'sd0) && (yi_w <= YMAX);
  assign x1_w     = (xi_w == XMAX) ? coord_x[31:16]
                                   : coord_x[31:16] + 16'd1;
  assign y1_w     = (yi_w == YMAX) ? coord_y[31:16]
                                   : coord_y[31:16] + 16'd1;

  always_comb begin
    xs_w = x0_q;
    ys_w = y0_q;
    case (cnt_q)
      2'd1: xs_w = x1_q;
      2'd2: ys_w = y1_q;
      2'd3: begin
        xs_w = x1_q;
        ys_w = y1_q;
      end
      default: ;
    endcase
  end

  assign addr_w = ADDR_W'(ys_w) * W_A + ADDR_W'(xs_w);

`ifdef VIDEO_BILINEAR_EN
  logic [31:0] fxw, fyw, ifx, ify;
  logic [31:0] top_w, bot_w, acc_w;
  logic        unused_w;

  assign fxw   = {24'd0, fx_q};
  assign fyw   = {24'd0, fy_q};
  assign ifx   = 32'd256 - fxw;
  assign ify   = 32'd256 - fyw;
  assign top_w = {24'd0, p_q[0]} * ifx + {24'd0, p_q[1]} * fxw;
  assign bot_w = {24'd0, p_q[2]} * ifx + {24'd0, p_q[3]} * fxw;
  assign acc_w = top_w * ify + bot_w * fyw + 32'd32768;
  assign calc_w = acc_w[23:16];
  assign unused_w = ^{acc_w[31:24], acc_w[15:0],
                      coord_x[7:0], coord_y[7:0]};
`else
  logic unused_w;

  assign calc_w   = p_q[0];
  assign unused_w = ^{p_q[1], p_q[2], p_q[3], fx_q, fy_q,
                      coord_x[15:0], coord_y[15:0]};
`endif

  assign coord_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign pix_valid   = (state_q == S_OUT);
  assign pix_out     = pix_q;
  assign mem_rd      = (state_q == S_FETCH);
  assign mem_addr    = mem_rd ? addr_w : addr_hold_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      fx_q        <= '0;
      fy_q        <= '0;
      cnt_q       <= '0;
      cap_q       <= 1'b0;
      cap_idx_q   <= '0;
      pix_q       <= '0;
      addr_hold_q <= '0;
      for (int i = 0; i < 4; i++) p_q[i] <= '0;
    end else begin
      // Read data lags the strobe by one cycle; tag it with its slot.
      cap_q     <= mem_rd;
      cap_idx_q <= cnt_q;
      if (cap_q) p_q[cap_idx_q] <= mem_rdata;
      case (state_q)
        S_IDLE: begin
          if (coord_valid) begin
            x0_q  <= coord_x[31:16];
            y0_q  <= coord_y[31:16];
            x1_q  <= x1_w;
            y1_q  <= y1_w;
            fx_q  <= coord_x[15:8];
            fy_q  <= coord_y[15:8];
            cnt_q <= '0;
            if (in_rng_w) begin
              state_q <= S_FETCH;
            end else begin
              pix_q   <= BG_PIXEL;
              state_q <= S_OUT;
            end
          end
        end
        S_FETCH: begin
          addr_hold_q <= addr_w;
          if (cnt_q == CLST) begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        S_WAIT: state_q <= S_CALC;
        S_CALC: begin
          pix_q   <= calc_w;
          state_q <= S_OUT;
        end
        S_OUT: begin
          if (pix_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_bilinear_interp.sv
// Directed bench for video_bilinear_interp in either build mode.
// Memory model answers reads one cycle after the strobe.
module tb_video_bilinear_interp;

`ifdef VIDEO_BILINEAR_EN
  localparam int LAT = 7;
  localparam int NRD = 4;
  localparam bit BIL = 1'b1;
`else
  localparam int LAT = 4;
  localparam int NRD = 1;
  localparam bit BIL = 1'b0;
`endif
  localparam logic [7:0] BG = 8'hA5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        coord_valid = 1'b0;
  logic        coord_ready;
  logic [31:0] coord_x = '0;
  logic [31:0] coord_y = '0;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [7:0]  pix_out;
  logic        busy;

  logic [7:0] mem [4096];
  int         addr_q [$];
  int         checks = 0;
  int         failures = 0;

  video_bilinear_interp #(
    .SRC_W(64), .SRC_H(64), .ADDR_W(12), .BG_PIXEL(BG)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .coord_valid(coord_valid), .coord_ready(coord_ready),
    .coord_x(coord_x), .coord_y(coord_y),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_out(pix_out), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      addr_q.push_back(int'(mem_addr));
    end
  end

  task automatic start(input logic [31:0] x, input logic [31:0] y,
                       output int lat);
    addr_q.delete();
    @(negedge clk);
    coord_x = x;
    coord_y = y;
    coord_valid = 1'b1;
    @(posedge clk);
    #1;
    coord_valid = 1'b0;
    lat = 1;
    while (!pix_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    pix_ready = 1'b1;
    @(posedge clk);
    #1;
    pix_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks += 6;
    if (mem_rd !== 1'b0) begin
      failures++; $display("FAIL rst_mem_rd got=%b exp=0", mem_rd);
    end
    if (mem_addr !== 12'd0) begin
      failures++; $display("FAIL rst_mem_addr got=%0d exp=0", mem_addr);
    end
    if (pix_valid !== 1'b0) begin
      failures++; $display("FAIL rst_pix_valid got=%b exp=0", pix_valid);
    end
    if (pix_out !== 8'd0) begin
      failures++; $display("FAIL rst_pix_out got=%0d exp=0", pix_out);
    end
    if (busy !== 1'b0) begin
      failures++; $display("FAIL rst_busy got=%b exp=0", busy);
    end
    if (coord_ready !== 1'b1) begin
      failures++; $display("FAIL rst_coord_ready got=%b exp=1", coord_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_addr();
    int lat;
    int exp_a [4] = '{197, 198, 261, 262};
    start(32'h0005_0000, 32'h0003_0000, lat);
    checks += 4;
    if (lat !== LAT) begin
      failures++; $display("FAIL addr_latency got=%0d exp=%0d", lat, LAT);
    end
    if (addr_q.size() !== NRD) begin
      failures++;
      $display("FAIL addr_count got=%0d exp=%0d", addr_q.size(), NRD);
    end else begin
      for (int i = 0; i < NRD; i++) begin
        checks++;
        if (addr_q[i] !== exp_a[i]) begin
          failures++;
          $display("FAIL addr_seq[%0d] got=%0d exp=%0d",
                   i, addr_q[i], exp_a[i]);
        end
      end
    end
    if (pix_out !== mem[197]) begin
      failures++; $display("FAIL addr_pix got=%0d exp=%0d", pix_out, mem[197]);
    end
    if (busy !== 1'b1 || coord_ready !== 1'b0) begin
      failures++;
      $display("FAIL addr_busy got=%b/%b exp=1/0", busy, coord_ready);
    end
    drain();
    checks++;
    if (pix_valid !== 1'b0 || coord_ready !== 1'b1) begin
      failures++;
      $display("FAIL addr_done got=%b/%b exp=0/1", pix_valid, coord_ready);
    end
  endtask

  task automatic test_blend_mid();
    int lat;
    logic [7:0] exp_p;
    mem[130] = 8'd0;
    mem[131] = 8'd100;
    mem[194] = 8'd100;
    mem[195] = 8'd200;
    exp_p = BIL ? 8'd100 : 8'd0;
    start(32'h0002_8000, 32'h0002_8000, lat);
    checks += 2;
    if (lat !== LAT) begin
      failures++; $display("FAIL mid_latency got=%0d exp=%0d", lat, LAT);
    end
    if (pix_out !== exp_p) begin
      failures++; $display("FAIL mid_pix got=%0d exp=%0d", pix_out, exp_p);
    end
    drain();
  endtask

  task automatic test_round();
    int lat;
    logic [7:0] exp_p;
    mem[0]  = 8'd0;
    mem[1]  = 8'd255;
    mem[64] = 8'd0;
    mem[65] = 8'd255;
    exp_p = BIL ? 8'd64 : 8'd0;
    start(32'h0000_4000, 32'h0000_0000, lat);
    checks++;
    if (pix_out !== exp_p) begin
      failures++; $display("FAIL round_pix got=%0d exp=%0d", pix_out, exp_p);
    end
    drain();
  endtask

  task automatic test_oor();
    int lat;
    logic [31:0] xs [2] = '{32'hFFFF_0000, 32'h0000_0000};
    logic [31:0] ys [2] = '{32'h0000_0000, 32'h0040_0000};
    for (int k = 0; k < 2; k++) begin
      start(xs[k], ys[k], lat);
      checks += 3;
      if (lat !== 1) begin
        failures++; $display("FAIL oor%0d_latency got=%0d exp=1", k, lat);
      end
      if (addr_q.size() !== 0) begin
        failures++;
        $display("FAIL oor%0d_reads got=%0d exp=0", k, addr_q.size());
      end
      if (pix_out !== BG) begin
        failures++;
        $display("FAIL oor%0d_pix got=%0h exp=%0h", k, pix_out, BG);
      end
      drain();
    end
  endtask

  task automatic test_edge_clamp();
    int lat;
    logic [7:0] exp_p;
    mem[1087] = 8'd40;
    mem[1151] = 8'd80;
    exp_p = BIL ? 8'd60 : 8'd40;
    start(32'h003F_8000, 32'h0010_8000, lat);
    checks += 2;
    if (addr_q.size() !== NRD) begin
      failures++;
      $display("FAIL clamp_count got=%0d exp=%0d", addr_q.size(), NRD);
    end else if (addr_q[0] !== 1087 ||
                 (BIL && (addr_q[1] !== 1087 || addr_q[2] !== 1151 ||
                          addr_q[3] !== 1151))) begin
      failures++;
      $display("FAIL clamp_addr got=%0d,%0d exp=1087,1087",
               addr_q[0], BIL ? addr_q[1] : addr_q[0]);
    end
    if (pix_out !== exp_p) begin
      failures++; $display("FAIL clamp_pix got=%0d exp=%0d", pix_out, exp_p);
    end
    drain();
  endtask

  task automatic test_stall();
    int lat;
    start(32'h0005_0000, 32'h0003_0000, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (pix_valid !== 1'b1 || pix_out !== mem[197] ||
          coord_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall%0d got=%b/%0d/%b exp=1/%0d/0",
                 i, pix_valid, pix_out, coord_ready, mem[197]);
      end
    end
    drain();
    checks++;
    if (pix_valid !== 1'b0 || coord_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_release got=%b/%b/%b exp=0/1/0",
               pix_valid, coord_ready, busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [7:0] exp_p;
    @(negedge clk);
    coord_x = 32'h0005_0000;
    coord_y = 32'h0003_0000;
    coord_valid = 1'b1;
    @(posedge clk);
    #1;
    coord_valid = 1'b0;
    checks++;
    if (mem_rd !== 1'b1) begin
      failures++; $display("FAIL midrst_fetch got=%b exp=1", mem_rd);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_rd !== 1'b0 || pix_valid !== 1'b0 || busy !== 1'b0 ||
        coord_ready !== 1'b1 || mem_addr !== 12'd0) begin
      failures++;
      $display("FAIL midrst_outs got=%b/%b/%b/%b/%0d exp=0/0/0/1/0",
               mem_rd, pix_valid, busy, coord_ready, mem_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_p = BIL ? 8'd100 : 8'd0;
    start(32'h0002_8000, 32'h0002_8000, lat);
    checks += 2;
    if (lat !== LAT) begin
      failures++; $display("FAIL midrst_latency got=%0d exp=%0d", lat, LAT);
    end
    if (pix_out !== exp_p) begin
      failures++; $display("FAIL midrst_pix got=%0d exp=%0d", pix_out, exp_p);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int lat;
    start(32'h0002_8000, 32'h0002_8000, lat);
    @(negedge clk);
    pix_ready = 1'b1;
    coord_x = 32'h0005_0000;
    coord_y = 32'h0003_0000;
    coord_valid = 1'b1;
    @(posedge clk);
    #1;
    pix_ready = 1'b0;
    checks++;
    if (coord_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle got=%b/%b exp=1/0", coord_ready, busy);
    end
    addr_q.delete();
    @(posedge clk);
    #1;
    coord_valid = 1'b0;
    lat = 1;
    while (!pix_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks += 2;
    if (lat !== LAT) begin
      failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT);
    end
    if (pix_out !== mem[197]) begin
      failures++; $display("FAIL b2b_pix got=%0d exp=%0d", pix_out, mem[197]);
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
    test_reset();
    test_addr();
    test_blend_mid();
    test_round();
    test_oor();
    test_edge_clamp();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
